// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel button debouncer sharing one sample-tick prescaler
// Auto-repeat on held buttons is built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debouncer_multi #(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 150
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] pulse_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press,
    output logic                tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

    if (CHANNELS < 1 || CHANNELS > 16 || TICK_DIV < 2 || STABLE_TICKS < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("debouncer_multi: parameter out of range");
    end

    logic [PW-1:0]         presc;
    logic [CHANNELS-1:0]   sync_a;
    logic [CHANNELS-1:0]   sync_b;
    logic [SW-1:0]         stab_cnt [CHANNELS];
    logic [CHANNELS-1:0]   accept;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (presc == TICK_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == TICK_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= pulse_in;
            sync_b <= sync_a;
        end
    end

    // A channel flips on the tick that completes STABLE_TICKS of continuous disagreement.
    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = tick && (sync_b[i] != level_out[i]) && (stab_cnt[i] == STABLE_LAST);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_out <= '0;
            rise      <= '0;
            fall      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            level_out <= (level_out & ~accept) | (sync_b & accept);
            rise      <= accept & sync_b;
            fall      <= accept & ~sync_b;
            for (int i = 0; i < CHANNELS; i++) begin
                if (sync_b[i] == level_out[i] || accept[i]) begin
                    stab_cnt[i] <= '0;
                end else if (tick) begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0]       rep_cnt [CHANNELS];
    logic [CHANNELS-1:0] rep_phase;
    logic [CHANNELS-1:0] rep_fire;

    // rep_phase selects the initial delay (0) or the steady repeat period (1).
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rep_fire[i] = tick && level_out[i] && !accept[i] &&
                          (rep_cnt[i] == (rep_phase[i] ? RATE_LAST : DELAY_LAST));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            press     <= '0;
            rep_phase <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            press <= (accept & sync_b) | rep_fire;
            for (int i = 0; i < CHANNELS; i++) begin
                if (!level_out[i] || accept[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b1;
                end else if (tick) begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            press <= '0;
        end else begin
            press <= accept & sync_b;
        end
    end
`endif

endmodule

// File: doc/debouncer_multi.md
DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of independent button channels (1..16).
REQ-002 The block SHALL have parameter TICK_DIV, default 50000, clock cycles per sample tick (1 ms at 50 MHz, minimum 2).
REQ-003 The block SHALL have parameter STABLE_TICKS, default 20, consecutive ticks of disagreement needed to accept a new level (minimum 1).
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 500, ticks from accepted press to first repeat; it is used only with DEBOUNCE_AUTOREPEAT_EN.
REQ-005 The block SHALL have parameter REPEAT_RATE, default 150, ticks between subsequent repeats; it is used only with DEBOUNCE_AUTOREPEAT_EN.
REQ-006 The block SHALL have port clock, input, 1 bit, system clock, rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port pulse_in, input, CHANNELS bits, raw bouncing asynchronous button inputs.
REQ-009 The block SHALL have port level_out, output, CHANNELS bits, debounced level per channel.
REQ-010 The block SHALL have port rise, output, CHANNELS bits, one-cycle pulse on each accepted 0->1 transition.
REQ-011 The block SHALL have port fall, output, CHANNELS bits, one-cycle pulse on each accepted 1->0 transition.
REQ-012 The block SHALL have port press, output, CHANNELS bits, one-cycle "action" pulse (rise, plus repeats when enabled).
REQ-013 The block SHALL have port tick, output, 1 bit, shared sample-tick strobe, one cycle wide.

Function
REQ-014 The prescaler SHALL count 0..TICK_DIV-1, assert tick for one cycle when the count equals TICK_DIV-1, and wrap to 0 on that cycle.
REQ-015 Each pulse_in bit SHALL pass through a two-flop synchronizer, giving sync[i]; no other logic samples pulse_in directly.
REQ-016 Whenever sync[i] equals level_out[i], on any cycle, the channel stability counter SHALL clear to 0.
REQ-017 While sync[i] differs from level_out[i], the counter SHALL increment on each tick; on the tick where the counter equals STABLE_TICKS-1, level_out[i] SHALL take sync[i] and the counter SHALL clear.
REQ-018 Any single-cycle return of sync[i] to level_out[i] SHALL restart qualification, so glitches shorter than one tick period between ticks are rejected.
REQ-019 rise[i]/fall[i] SHALL be registered and asserted in the first cycle level_out[i] shows the new value, for exactly one cycle.
REQ-020 rise[i] and fall[i] SHALL never both be asserted; channels SHALL be fully independent and may update in the same cycle.
REQ-021 Worst-case latency from a stable pulse_in change to level_out SHALL be 2 sync cycles plus STABLE_TICKS*TICK_DIV cycles plus 1 cycle.
REQ-022 Counter widths SHALL be sized by ceiling log2 of the maximum count; no counter SHALL wrap past its terminal value.

Reset
REQ-023 While reset_n is 0, level_out, rise, fall, press, tick, synchronizers, prescaler and all channel counters SHALL be 0.
REQ-024 A button held at release of reset SHALL be reported as a rise after normal qualification, never instantly.
REQ-025 Reset asserted mid-qualification or mid-repeat SHALL discard all progress with no spurious pulse after release.

Configuration
REQ-026 With DEBOUNCE_AUTOREPEAT_EN defined, each channel SHALL keep a repeat counter cleared on rise; while level_out[i]=1 it counts ticks, pulses press[i] at REPEAT_DELAY ticks, then every REPEAT_RATE ticks; fall stops repeats immediately.
REQ-027 With DEBOUNCE_AUTOREPEAT_EN defined, press[i] SHALL equal rise[i] OR the repeat strobe.
REQ-028 Without DEBOUNCE_AUTOREPEAT_EN defined, no repeat counters SHALL be synthesized, press SHALL equal rise, and REPEAT_DELAY/REPEAT_RATE SHALL be ignored.

Verification (CHANNELS=2, TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-029 The bench SHALL cover: reset, then pulse_in=2'b01 held -> tick every 4th cycle; level_out[0]=1 and rise[0]=1 for one cycle within 2+12+1 cycles; channel 1 stays 0.
REQ-030 The bench SHALL cover: channel 0 bouncing 1/0 every 3 cycles for 40 cycles -> level_out[0] stays 0; no rise/press pulses.
REQ-031 The bench SHALL cover: both channels rising in the same cycle, then released -> simultaneous rise on both bits; later fall on both bits, one cycle each.
REQ-032 The bench SHALL cover: reset_n pulled low 2 ticks into qualification, then released with input held -> no pulse during reset; rise appears a full 3 ticks after release.
REQ-033 The bench SHALL cover, with macro defined: channel 0 held 20 ticks -> press at rise, again 5 ticks later, then every 2 ticks; release -> repeats stop, fall pulses once.
REQ-034 The bench SHALL cover, with macro undefined: the same hold -> exactly one press pulse, coincident with rise.
